// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instruction words from imem
// and holds the fetched word for the control unit until it is consumed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] instret,
    output logic        dbg_state
);

    typedef enum logic {FETCH = 1'b0, VALID = 1'b1} state_t;

    // Handshake: a word transfers on any rising edge where imem_req && imem_ready;
    // an instruction is consumed on any rising edge where instr_valid && !stall.
    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        misaligned_q;
    logic [31:0] instret_q;

    assign PCPlus4    = pc_q + 32'd4;
    assign fetch_pc_d = PCSrc ? {PCTarget[31:2], 2'b00} : PCPlus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            misaligned_q <= 1'b0;
            instret_q    <= 32'd0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        pc_q    <= fetch_pc_q;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        fetch_pc_q   <= fetch_pc_d;
                        instret_q    <= instret_q + 32'd1;
                        instr_q      <= NOP;
                        misaligned_q <= PCSrc && (PCTarget[1:0] != 2'b00);
                        state_q      <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Request is gated by reset so it stays low while the core is held in reset.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (state_q == VALID);
    assign dbg_state   = state_q;

    assign Instr      = instr_q;
    assign op         = instr_q[6:0];
    assign funct3     = instr_q[14:12];
    assign funct7b5   = instr_q[30];
    assign PC         = pc_q;
    assign misaligned = misaligned_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/consume sequences, with a
// monitor comparing each newly presented instruction against an expected queue.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misaligned;
    logic [31:0] instret;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_ret;
    logic        prev_valid;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .Instr(Instr), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .PC(PC), .PCPlus4(PCPlus4), .instr_valid(instr_valid),
        .misaligned(misaligned), .instret(instret), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: each newly presented instruction pops one expected {PC, Instr}
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h want nothing", PC, Instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_pc", PC, e[63:32]);
                check("sb_instr", Instr, e[31:0]);
            end
        end
        prev_valid = instr_valid;
    end

    // driver: serve one fetch at exp_addr after 'waits' not-ready cycles
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
        check("req_hi", {31'd0, imem_req}, 32'd1);
        check("addr", imem_addr, addr);
        check("invalid_in_fetch", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            imem_rdata = 32'hDEAD_0000 + i;
            tick();
            check("wait_addr_stable", imem_addr, addr);
            check("wait_invalid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        exp_q.push_back({addr, word});
        exp_pc    = addr;
        exp_instr = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        check("valid_after_capture", {31'd0, instr_valid}, 32'd1);
        check("dbg_state_valid", {31'd0, dbg_state}, 32'd1);
    endtask

    // driver: stall n cycles (PCSrc toggling, ready noise), then consume
    task automatic consume(input int n, input logic src, input logic [31:0] tgt);
        for (int i = 0; i < n; i++) begin
            stall      = 1'b1;
            PCSrc      = i[0];
            PCTarget   = 32'h0000_0200 + i;
            imem_ready = 1'b1;
            tick();
            check("stall_pc", PC, exp_pc);
            check("stall_instr", Instr, exp_instr);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ready = 1'b0;
        stall      = 1'b0;
        PCSrc      = src;
        PCTarget   = tgt;
        tick();
        PCSrc    = 1'b0;
        PCTarget = 32'd0;
        exp_ret  = exp_ret + 32'd1;
        check("instret", instret, exp_ret);
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'd0;
        exp_pc     = 32'd0;
        exp_instr  = NOP;
        exp_ret    = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", PC, 32'd0);
        check("rst_instr", Instr, NOP);
        check("rst_op", {25'd0, op}, 32'h13);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_instret", instret, 32'd0);
        reset = 1'b0;
        #1;

        // zero-wait fetch of an R-type at 0
        fetch(32'h0, 32'h0000_0033, 0);
        check("op_rtype", {25'd0, op}, 32'h33);
        check("pcplus4_0", PCPlus4, 32'h4);
        consume(0, 1'b0, 32'h0);
        fetch(32'h4, 32'h4000_5013, 0);
        check("funct3_srai", {29'd0, funct3}, 32'd5);
        check("f7b5_srai", {31'd0, funct7b5}, 32'd1);
        consume(0, 1'b0, 32'h0);
        fetch(32'h8, 32'h0000_0033, 0);
        check("f7b5_add", {31'd0, funct7b5}, 32'd0);
        consume(0, 1'b0, 32'h0);
        check("instret_3", instret, 32'd3);

        // three wait cycles, then stall with PCSrc toggling and a taken release
        fetch(32'hC, 32'h0000_0063, 3);
        consume(4, 1'b1, 32'h0000_0100);
        check("no_mis_aligned", {31'd0, misaligned}, 32'd0);
        fetch(32'h100, 32'h0000_006F, 0);

        // misaligned taken target
        consume(0, 1'b1, 32'h0000_0102);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        fetch(32'h100, 32'h0000_0067, 1);
        check("mis_cleared", {31'd0, misaligned}, 32'd0);

        // reset while waiting in FETCH at 0x40, with a response arriving during reset
        consume(0, 1'b1, 32'h0000_0040);
        fetch(32'h40, 32'h0000_0033, 0);
        consume(0, 1'b0, 32'h0);
        check("addr_44", imem_addr, 32'h44);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, 32'd0);
        check("arst_pc", PC, 32'd0);
        check("arst_instr", Instr, NOP);
        check("arst_instret", instret, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        check("arst_not_captured", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b0;
        reset      = 1'b0;
        exp_ret    = 32'd0;
        #1;

        // restart at reset PC, jump to top of memory, check wrap; stall during capture
        fetch(32'h0, 32'h0000_0013, 0);
        consume(0, 1'b1, 32'hFFFF_FFFC);
        stall = 1'b1;
        fetch(32'hFFFF_FFFC, 32'h0000_0033, 0);
        check("wrap_pc", PC, 32'hFFFF_FFFC);
        check("wrap_pcplus4", PCPlus4, 32'h0);
        consume(0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of `cu`. It holds the program counter and issues requests to instruction memory. It captures the returned word into an instruction register and presents `op`, `funct3` and `funct7b5` to `cu`. When the current instruction is consumed, it selects the next PC from `PCSrc`/`PCTarget`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `NOP`, default 32'h0000_0013: value held in the instruction register when no valid instruction is present (addi x0,x0,0).

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; equals the internal PC.
- `imem_rdata`  in  32: instruction word; sampled only when `imem_req && imem_ready`.
- `imem_ready`  in  1: memory returns `imem_rdata` this cycle; ignored when `imem_req`=0.
- `stall`  in  1: downstream not accepting; holds the current instruction.
- `PCSrc`  in  1: branch/jump taken, from `cu`; sampled only on consume.
- `PCTarget`  in  32: taken target address; sampled only on consume.
- `Instr`  out  32: instruction register.
- `op`  out  7: `Instr[6:0]`.
- `funct3`  out  3: `Instr[14:12]`.
- `funct7b5`  out  1: `Instr[30]`.
- `PC`  out  32: address of `Instr`.
- `PCPlus4`  out  32: `PC + 4`, modulo 2^32.
- `instr_valid`  out  1: `Instr`/`PC` hold a valid fetched instruction.
- `misaligned`  out  1: one-cycle pulse when a taken `PCTarget` has bits [1:0] ≠ 0.
- `instret`  out  32: count of consumed instructions, wraps modulo 2^32.

## Operation
- State machine has two states, `FETCH` and `VALID`. The state register is cleared to `FETCH` by `reset`.
- In `FETCH`:
  - `imem_req`=1, `imem_addr`=fetch PC, `instr_valid`=0.
  - On `imem_ready`=1: `Instr`←`imem_rdata`, `PC`←fetch PC, go to `VALID`.
  - Otherwise remain in `FETCH` with the address held stable.
- In `VALID`:
  - `imem_req`=0, `instr_valid`=1.
  - A consume occurs when `stall`=0.
  - On consume, fetch PC ← `PCSrc` ? {`PCTarget`[31:2],2'b00} : `PCPlus4`.
  - On consume, `instret` increments and the state goes to `FETCH`.
  - `stall`=1 holds `Instr`, `PC` and the state unchanged; `PCSrc` and `PCTarget` are ignored while stalled.
- `misaligned` pulses high for exactly the cycle after a consume where `PCSrc`=1 and `PCTarget[1:0]`≠0. The fetch still proceeds to the cleared-low-bits address.
- `PCPlus4` wraps: `PC`=32'hFFFF_FFFC gives `PCPlus4`=32'h0000_0000.
- `op`, `funct3` and `funct7b5` are pure slices of `Instr`. They are always driven, including `NOP` fields when invalid.
- `imem_ready` with `imem_req`=0 (state `VALID`) has no effect.

## Timing
- Reset values (held while `reset`=1):
  - fetch PC = `PC` = `RESET_PC`; `Instr`=`NOP`; `instr_valid`=0.
  - `imem_req`=0; `misaligned`=0; `instret`=0.
- First edge after `reset` deasserts: state is `FETCH`, so `imem_req`=1 combinationally with `imem_addr`=`RESET_PC`.
- Fetch latency:
  - With `imem_ready` high in the first `FETCH` cycle, `instr_valid`=1 the following cycle.
  - Each extra wait cycle adds one cycle.
- Throughput with zero-wait memory and no stall is one instruction per 2 cycles (`FETCH`, `VALID`).
- `imem_req`, `imem_addr` and `instr_valid` are decoded from state and registers only. There is no combinational path from `imem_ready`, `stall` or `PCSrc` to them.
- Reset mid-operation:
  - Any state is abandoned asynchronously.
  - An outstanding memory response is not captured.
  - Fetch restarts at `RESET_PC`.
- `stall` and `imem_ready` high in the same cycle while in `FETCH`: the instruction is captured, because `stall` only affects `VALID`.

## Test plan
- Reset, then zero-wait memory returning 32'h0000_0033 at 0x0 -> `imem_addr`=0x0; next cycle `instr_valid`=1, `op`=7'b0110011, `PC`=0, `PCPlus4`=4.
- Sequential fetch, `PCSrc`=0, no stall, 3 instructions -> addresses 0x0, 0x4, 0x8; `instret`=3.
- `imem_ready` low for 3 cycles in `FETCH` -> `imem_addr` stable and `instr_valid`=0 throughout; capture on the 4th cycle.
- `stall`=1 for 4 cycles in `VALID` with `PCSrc` toggling -> `Instr`/`PC` unchanged and no request; on release with `PCSrc`=1, `PCTarget`=0x100 -> next `imem_addr`=0x100.
- Taken target 0x102 -> `misaligned` pulses one cycle and the fetch goes to 0x100.
- Assert `reset` during a `FETCH` wait, with `PC` at 0x40 -> all outputs at reset values asynchronously; after release, fetch at `RESET_PC`; also check the `PC`=0xFFFF_FFFC wrap to `PCPlus4`=0.
